// File: rtl/pwm_pkg.sv
// Shared defaults and the ramp state encoding for the PWM duty ramp controller.
package pwm_pkg;

    localparam int COUNTER_BITS_DEF = 8;
    localparam int TIMER_BITS_DEF   = 4;
    localparam int DWELL_BITS_DEF   = 8;
    localparam int DUTY_MAX         = 2 ** COUNTER_BITS_DEF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/period_dwell_counter.sv
// Counts PWM period wraps and flags the wrap on which the programmed dwell is reached.
module period_dwell_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [WIDTH-1:0] limit,
    output logic             hit
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH:0]   count_inc;

    // One extra bit so a full-scale limit never wraps the comparison.
    assign count_inc = {1'b0, count_reg} + {{WIDTH{1'b0}}, 1'b1};
    assign hit       = tick && !clr && (count_inc >= {1'b0, limit});

    always_comb begin
        count_next = count_reg;
        if (clr || hit) begin
            count_next = '0;
        end else if (tick) begin
            count_next = count_inc[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps the applied PWM duty toward a commanded target in saturating steps, one
// step per programmed number of PWM periods, and applies a new prescaler value.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int COUNTER_BITS = COUNTER_BITS_DEF,
    parameter int TIMER_BITS   = TIMER_BITS_DEF,
    parameter int DWELL_BITS   = DWELL_BITS_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [COUNTER_BITS:0]   cmd_duty,
    input  logic [COUNTER_BITS-1:0] cmd_step,
    input  logic [DWELL_BITS-1:0]   cmd_dwell,
    input  logic [TIMER_BITS-1:0]   cmd_prescale,
    input  logic                    period_wrap,
    input  logic                    abort,
    output logic [COUNTER_BITS:0]   duty,
    output logic [TIMER_BITS-1:0]   final_value,
    output logic                    busy,
    output logic                    done
);

    localparam int DW = COUNTER_BITS + 1;
    localparam int AW = COUNTER_BITS + 2;
    localparam logic [DW-1:0] FULL_SCALE = {1'b1, {COUNTER_BITS{1'b0}}};

    ramp_state_t             state_reg, state_next;
    logic [DW-1:0]           duty_reg, duty_next;
    logic [DW-1:0]           target_reg, target_next;
    logic [COUNTER_BITS-1:0] step_reg, step_next;
    logic [DWELL_BITS-1:0]   dwell_reg, dwell_next;
    logic [TIMER_BITS-1:0]   prescale_reg, prescale_next;
    logic                    pend_reg, pend_next;
    logic [TIMER_BITS-1:0]   final_value_reg, final_value_next;
    logic                    done_reg, done_next;

    logic                    accept;
    logic                    dwell_clr;
    logic                    dwell_hit;
    logic [DW-1:0]           cmd_target;
    logic [COUNTER_BITS-1:0] cmd_step_sat;
    logic [DWELL_BITS-1:0]   cmd_dwell_sat;
    logic [AW-1:0]           duty_w, target_w, step_w, up_sum, dn_floor;
    logic [DW-1:0]           up_val, dn_val;

    assign busy        = (state_reg != IDLE);
    assign cmd_ready   = (state_reg == IDLE) && !abort && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign duty        = duty_reg;
    assign final_value = final_value_reg;
    assign done        = done_reg;

    // Command sanitising: clamp the target to 100%, and treat zero step/dwell as one.
    assign cmd_target    = (cmd_duty > FULL_SCALE) ? FULL_SCALE : cmd_duty;
    assign cmd_step_sat  = (cmd_step == '0) ? COUNTER_BITS'(1) : cmd_step;
    assign cmd_dwell_sat = (cmd_dwell == '0) ? DWELL_BITS'(1) : cmd_dwell;

    // Two bits of headroom above the counter width keep both step directions exact.
    assign duty_w   = {1'b0, duty_reg};
    assign target_w = {1'b0, target_reg};
    assign step_w   = {2'b00, step_reg};
    assign up_sum   = duty_w + step_w;
    assign dn_floor = target_w + step_w;
    assign up_val   = (up_sum >= target_w) ? target_reg : DW'(up_sum);
    assign dn_val   = (duty_w >= dn_floor) ? DW'(duty_w - step_w) : target_reg;

    assign dwell_clr = abort || !busy;

    period_dwell_counter #(
        .WIDTH (DWELL_BITS)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr   (dwell_clr),
        .tick  (period_wrap),
        .limit (dwell_reg),
        .hit   (dwell_hit)
    );

    always_comb begin
        state_next       = state_reg;
        duty_next        = duty_reg;
        target_next      = target_reg;
        step_next        = step_reg;
        dwell_next       = dwell_reg;
        prescale_next    = prescale_reg;
        pend_next        = pend_reg;
        final_value_next = final_value_reg;
        done_next        = 1'b0;

        if (abort) begin
            state_next = IDLE;
            duty_next  = '0;
            pend_next  = 1'b0;
        end else begin
            if (pend_reg && period_wrap) begin
                final_value_next = prescale_reg;
                pend_next        = 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        target_next   = cmd_target;
                        step_next     = cmd_step_sat;
                        dwell_next    = cmd_dwell_sat;
                        prescale_next = cmd_prescale;
                        pend_next     = 1'b1;
                        if (cmd_target > duty_reg) begin
                            state_next = RAMP_UP;
                        end else if (cmd_target < duty_reg) begin
                            state_next = RAMP_DOWN;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                RAMP_UP: begin
                    if (dwell_hit) begin
                        duty_next = up_val;
                        if (up_val == target_reg) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                RAMP_DOWN: begin
                    if (dwell_hit) begin
                        duty_next = dn_val;
                        if (dn_val == target_reg) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            duty_reg        <= '0;
            target_reg      <= '0;
            step_reg        <= '0;
            dwell_reg       <= '0;
            prescale_reg    <= '0;
            pend_reg        <= 1'b0;
            final_value_reg <= '0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            duty_reg        <= duty_next;
            target_reg      <= target_next;
            step_reg        <= step_next;
            dwell_reg       <= dwell_next;
            prescale_reg    <= prescale_next;
            pend_reg        <= pend_next;
            final_value_reg <= final_value_next;
            done_reg        <= done_next;
        end
    end

endmodule
